// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package wb_pkg;

  localparam int DEFAULT_XLEN       = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  typedef struct packed {
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic [DEFAULT_XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic is_x0(input logic [DEFAULT_REG_ADDR_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; the head is readable in the same
// cycle so a freshly pushed result can be written back two cycles after its push.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU results win, long-latency results drain from a FIFO.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rsta,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data
);

  wb_entry_t             ll_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  alu_win;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  assign ll_entry = '{rd: ll_rd, data: ll_data};
  assign ll_ready = !fifo_full;
  assign push     = ll_valid && ll_ready;
  assign alu_win  = alu_valid && !alu_stall;
  assign pop      = !alu_win && !fifo_empty;

  wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rsta),
    .push       (push),
    .push_entry (ll_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign sel_valid = alu_win || pop;
  assign sel_rd    = alu_win ? alu_rd   : head.rd;
  assign sel_data  = alu_win ? alu_data : head.data;

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  // Counts cycles the full FIFO loses to the ALU; the stall forces one pop.
  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      starve_cnt <= '0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (fifo_full && alu_win) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign alu_stall = (starve_cnt == CW'(STARVE_MAX));
`else
  assign alu_stall = 1'b0;
`endif

  // Selected result with rd=0 is consumed but never reaches the register file.
  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (sel_valid && !is_x0(sel_rd)) begin
      RegWrite   <= 1'b1;
      write_reg  <= sel_rd;
      write_data <= sel_data;
    end else begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (honours WB_STARVE_GUARD_EN if defined).
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rsta = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  regfile_wb_arbiter #(
    .XLEN(32), .REG_ADDR_W(5), .LL_DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rsta       (rsta),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_rd      (ll_rd),
    .ll_data    (ll_data),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  exp_t exp_q[$];
  ent_t model_q[$];
  int   model_starve = 0;
  bit   hold_valid = 0;
  logic [4:0]  hold_rd = '0;
  logic [31:0] hold_data = '0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every DUT write must match the oldest expected write and its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rsta) begin
        if (RegWrite) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_write at cycle %0d: got rd=%0d data=0x%0h, expected none",
                     cyc, write_reg, write_data);
          end else begin
            e = exp_q.pop_front();
            $display("write cycle=%0d rd=%0d data=0x%0h", cyc, write_reg, write_data);
            check("write_cycle", cyc, e.cyc);
            check("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
            check("write_data", write_data, e.data);
          end
        end else begin
          check("idle_reg", {27'd0, write_reg}, 32'd0);
          check("idle_data", write_data, 32'd0);
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write at cycle %0d: got no write, expected rd=%0d data=0x%0h",
                     cyc, e.rd, e.data);
          end
        end
      end
    end
  end

  // One cycle of stimulus plus the reference model of what it must produce.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit m_ready, m_stall, awin, popped;
    ent_t e;
    @(negedge clk);
    m_ready = (model_q.size() < DEPTH);
`ifdef WB_STARVE_GUARD_EN
    m_stall = (model_starve == STARVE_MAX);
`else
    m_stall = 0;
`endif
    check("ll_ready", {31'd0, ll_ready}, {31'd0, m_ready});
    check("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall});
    if (hold_valid) begin
      av = 1'b1; ard = hold_rd; adat = hold_data;
    end
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ll_valid = lv; ll_rd = lrd; ll_data = ldat;
    awin = av && !m_stall;
    hold_valid = av && m_stall;
    hold_rd = ard; hold_data = adat;
    popped = 0;
    if (awin) begin
      if (ard != 0) exp_q.push_back('{cyc + 1, ard, adat});
    end else if (model_q.size() > 0) begin
      e = model_q.pop_front();
      popped = 1;
      if (e.rd != 0) exp_q.push_back('{cyc + 1, e.rd, e.data});
    end
    if (popped) model_starve = 0;
    else if (!m_ready && awin) model_starve++;
    if (lv && m_ready) model_q.push_back('{lrd, ldat});
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic rand_step(input int alu_pct, input int ll_pct);
    step($urandom_range(99) < alu_pct, 5'($urandom), $urandom,
         $urandom_range(99) < ll_pct, 5'($urandom), $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alu_valid = 0; ll_valid = 0;
    #1 rsta = 1'b1;
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_write_reg", {27'd0, write_reg}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
    exp_q.delete();
    model_q.delete();
    model_starve = 0;
    hold_valid = 0;
    repeat (2) @(negedge clk);
    rsta = 1'b0;
    #1;
    check("post_rst_ll_ready", {31'd0, ll_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (model_q.size() > 0 || hold_valid); i++) idle();
    repeat (3) idle();
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2 rsta = 1'b1;
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    repeat (2) @(negedge clk);
    rsta = 1'b0;
    #1;
    check("post_rst_ll_ready", {31'd0, ll_ready}, 32'd1);

    step(1, 5'd1, 32'hFF, 0, 5'd0, 32'd0);
    repeat (2) idle();
    step(0, 5'd0, 32'd0, 1, 5'd2, 32'hAA);
    repeat (3) idle();
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    repeat (3) idle();
    step(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0);
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
    repeat (3) idle();

    // Continuous ALU stream with LL pushes: fills the FIFO and exercises the guard.
    for (int i = 0; i < 24; i++)
      step(1, 5'($urandom_range(31, 1)), $urandom, 1, 5'($urandom_range(31, 1)), $urandom);
    drain();

    for (int i = 0; i < 300; i++) rand_step(60, 50);
    drain();

    // Queue three entries behind ALU traffic, then reset mid-operation.
    for (int i = 0; i < 3; i++)
      step(1, 5'($urandom_range(31, 1)), $urandom, 1, 5'($urandom_range(31, 1)), $urandom);
    do_reset();
    repeat (4) idle();

    for (int i = 0; i < 200; i++) rand_step(80, 70);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
